// File: rtl/uv_bus_apb_bridge_pkg.sv
// Shared definitions for the uv bus to APB3 bridge: FSM states and response exception codes.
package uv_bus_apb_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_e;

  localparam logic [1:0] UV_EXCP_OK     = 2'b00;
  localparam logic [1:0] UV_EXCP_SLVERR = 2'b01;
  localparam logic [1:0] UV_EXCP_TMO    = 2'b10;

  localparam int TMO_W = 16;

endpackage

// File: rtl/uv_bus_apb_bridge.sv
// uv bus slave port to APB3 master; one transfer in flight, optional ACCESS-phase timeout.
module uv_bus_apb_bridge
  import uv_bus_apb_bridge_pkg::*;
#(
  parameter int ALEN    = 32,
  parameter int DLEN    = 32,
  parameter int MLEN    = DLEN / 8,
  parameter int TMO_CYC = 256
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            bus_req_vld,
  output logic            bus_req_rdy,
  input  logic            bus_req_read,
  input  logic [ALEN-1:0] bus_req_addr,
  input  logic [MLEN-1:0] bus_req_mask,
  input  logic [DLEN-1:0] bus_req_data,
  output logic            bus_rsp_vld,
  input  logic            bus_rsp_rdy,
  output logic [1:0]      bus_rsp_excp,
  output logic [DLEN-1:0] bus_rsp_data,
  output logic            apb_psel,
  output logic            apb_penable,
  output logic            apb_pwrite,
  output logic [ALEN-1:0] apb_paddr,
  output logic [MLEN-1:0] apb_pstrb,
  output logic [DLEN-1:0] apb_pwdata,
  input  logic            apb_pready,
  input  logic            apb_pslverr,
  input  logic [DLEN-1:0] apb_prdata
);

  // APB3 carries 32-bit data only; other widths answer every request with a slave error.
  localparam bit UNSUP = (DLEN != 32);

  apb_state_e state, state_nxt;
  logic       req_hs;
  logic       tmo_hit;
  logic       acc_done;

  assign req_hs   = bus_req_vld & bus_req_rdy;
  assign acc_done = (state == ST_ACCESS) & apb_pready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    bus_req_rdy = 1'b0;
    bus_rsp_vld = 1'b0;
    apb_psel    = 1'b0;
    apb_penable = 1'b0;
    case (state)
      ST_IDLE: begin
        bus_req_rdy = 1'b1;
        if (bus_req_vld) state_nxt = UNSUP ? ST_RESP : ST_SETUP;
      end
      ST_SETUP: begin
        apb_psel  = 1'b1;
        state_nxt = ST_ACCESS;
      end
      ST_ACCESS: begin
        apb_psel    = 1'b1;
        apb_penable = 1'b1;
        if (apb_pready || tmo_hit) state_nxt = ST_RESP;
      end
      ST_RESP: begin
        bus_rsp_vld = 1'b1;
        if (bus_rsp_rdy) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Request fields are captured once so APB sees them stable for the whole transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      apb_pwrite   <= 1'b0;
      apb_paddr    <= '0;
      apb_pstrb    <= '0;
      apb_pwdata   <= '0;
      bus_rsp_excp <= UV_EXCP_OK;
      bus_rsp_data <= '0;
    end else if (req_hs) begin
      apb_pwrite   <= ~bus_req_read;
      apb_paddr    <= {bus_req_addr[ALEN-1:2], 2'b00};
      apb_pstrb    <= bus_req_read ? '0 : bus_req_mask;
      apb_pwdata   <= bus_req_data;
      bus_rsp_excp <= UNSUP ? UV_EXCP_SLVERR : UV_EXCP_OK;
      bus_rsp_data <= '0;
    end else if (acc_done) begin
      bus_rsp_excp <= apb_pslverr ? UV_EXCP_SLVERR : UV_EXCP_OK;
      bus_rsp_data <= (!apb_pwrite && !apb_pslverr) ? apb_prdata : '0;
    end else if (tmo_hit) begin
      bus_rsp_excp <= UV_EXCP_TMO;
      bus_rsp_data <= '0;
    end
  end

  generate
    if (TMO_CYC != 0) begin : g_tmo
      localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);
      logic [TMO_W-1:0] tmo_cnt;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                 tmo_cnt <= '0;
        else if (state == ST_SETUP)                 tmo_cnt <= '0;
        else if (state == ST_ACCESS && !apb_pready) tmo_cnt <= tmo_cnt + 1'b1;
      end

      // Fires on the TMO_CYC-th ACCESS cycle; a same-cycle PREADY takes priority via acc_done.
      assign tmo_hit = (state == ST_ACCESS) && !apb_pready && (tmo_cnt == TMO_LAST);
    end else begin : g_no_tmo
      assign tmo_hit = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_uv_bus_apb_bridge.sv
// Directed bench for uv_bus_apb_bridge with a response scoreboard and a delay-programmable APB slave.
module tb_uv_bus_apb_bridge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_vld = 1'b0, req_vld2 = 1'b0, req_read = 1'b0;
  logic [31:0] req_addr = '0, req_data = '0;
  logic [3:0]  req_mask = '0;
  logic        rsp_rdy = 1'b1;

  logic        req_rdy, rsp_vld, psel, penable, pwrite;
  logic [1:0]  rsp_excp;
  logic [31:0] rsp_data, paddr, pwdata;
  logic [3:0]  pstrb;
  logic        req_rdy2, rsp_vld2, psel2, penable2, pwrite2;
  logic [1:0]  rsp_excp2;
  logic [31:0] rsp_data2, paddr2, pwdata2;
  logic [3:0]  pstrb2;

  logic        pready, pslverr;
  logic [31:0] prdata;
  int          pready_dly = 0;
  bit          hang = 1'b0, slverr_on = 1'b0;
  logic [31:0] rdata_v = '0;
  int          acc_cnt = 0;

  typedef struct {logic [1:0] excp; logic [31:0] data;} exp_t;
  exp_t sb[$];
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  uv_bus_apb_bridge dut (
    .clk(clk), .rst_n(rst_n),
    .bus_req_vld(req_vld), .bus_req_rdy(req_rdy), .bus_req_read(req_read),
    .bus_req_addr(req_addr), .bus_req_mask(req_mask), .bus_req_data(req_data),
    .bus_rsp_vld(rsp_vld), .bus_rsp_rdy(rsp_rdy), .bus_rsp_excp(rsp_excp), .bus_rsp_data(rsp_data),
    .apb_psel(psel), .apb_penable(penable), .apb_pwrite(pwrite), .apb_paddr(paddr),
    .apb_pstrb(pstrb), .apb_pwdata(pwdata), .apb_pready(pready), .apb_pslverr(pslverr),
    .apb_prdata(prdata)
  );

  uv_bus_apb_bridge #(.TMO_CYC(4)) dut_t (
    .clk(clk), .rst_n(rst_n),
    .bus_req_vld(req_vld2), .bus_req_rdy(req_rdy2), .bus_req_read(req_read),
    .bus_req_addr(req_addr), .bus_req_mask(req_mask), .bus_req_data(req_data),
    .bus_rsp_vld(rsp_vld2), .bus_rsp_rdy(rsp_rdy), .bus_rsp_excp(rsp_excp2), .bus_rsp_data(rsp_data2),
    .apb_psel(psel2), .apb_penable(penable2), .apb_pwrite(pwrite2), .apb_paddr(paddr2),
    .apb_pstrb(pstrb2), .apb_pwdata(pwdata2), .apb_pready(pready), .apb_pslverr(pslverr),
    .apb_prdata(prdata)
  );

  // Slave: PREADY on the (pready_dly+1)-th ACCESS cycle unless hung.
  always @(posedge clk) begin
    if ((psel & penable) | (psel2 & penable2)) acc_cnt <= acc_cnt + 1;
    else                                       acc_cnt <= 0;
  end
  assign pready  = ((psel & penable) | (psel2 & penable2)) & ~hang & (acc_cnt == pready_dly);
  assign pslverr = slverr_on & pready;
  assign prdata  = rdata_v;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input bit u2, input bit rd, input logic [31:0] a, input logic [3:0] m,
                      input logic [31:0] d, input logic [1:0] ex, input logic [31:0] ed);
    exp_t e;
    @(negedge clk);
    chk("req_rdy_idle", u2 ? req_rdy2 : req_rdy, 1);
    req_read = rd; req_addr = a; req_mask = m; req_data = d;
    if (u2) req_vld2 = 1'b1; else req_vld = 1'b1;
    @(posedge clk);
    e.excp = ex; e.data = ed;
    sb.push_back(e);
    #1 req_vld = 1'b0; req_vld2 = 1'b0;
  endtask

  task automatic wait_rsp(input bit u2, input string tag);
    int   n = 0;
    exp_t e;
    while (!(u2 ? rsp_vld2 : rsp_vld) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_rsp_vld"}, u2 ? rsp_vld2 : rsp_vld, 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_excp"}, u2 ? rsp_excp2 : rsp_excp, e.excp);
      chk({tag, "_data"}, u2 ? rsp_data2 : rsp_data, e.data);
    end else begin
      chk({tag, "_sb_nonempty"}, 0, 1);
    end
    @(posedge clk);
  endtask

  initial begin
    int   cnt, bad;
    exp_t e;
    // Reset values
    #3;
    chk("rst_req_rdy", req_rdy, 1);
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_rsp_vld", rsp_vld, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pstrb", pstrb, 0);
    chk("rst_excp", rsp_excp, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // 1: write with zero-wait PREADY, latency check
    send(0, 0, 32'h1000_0004, 4'b0011, 32'hA5A5_5A5A, 2'b00, 32'h0);
    @(negedge clk);
    chk("t1_setup_psel", psel, 1);
    chk("t1_setup_penable", penable, 0);
    chk("t1_paddr", paddr, 32'h1000_0004);
    chk("t1_pstrb", pstrb, 4'b0011);
    chk("t1_pwrite", pwrite, 1);
    chk("t1_pwdata", pwdata, 32'hA5A5_5A5A);
    chk("t1_req_rdy_busy", req_rdy, 0);
    @(negedge clk);
    chk("t1_access_psel", psel, 1);
    chk("t1_access_penable", penable, 1);
    @(negedge clk);
    chk("t1_rsp_at_n3", rsp_vld, 1);
    wait_rsp(0, "t1");

    // 2: read with 5 wait states, unaligned address gets word aligned
    rdata_v = 32'hDEAD_BEEF; pready_dly = 5;
    send(0, 1, 32'h1000_000B, 4'b1111, 32'h0, 2'b00, 32'hDEAD_BEEF);
    cnt = 0; bad = 0;
    for (int i = 0; i < 30 && !rsp_vld; i++) begin
      @(negedge clk);
      if (penable) begin
        cnt++;
        if (paddr !== 32'h1000_0008 || psel !== 1'b1 || pwrite !== 1'b0 || pstrb !== 4'b0) bad++;
      end
    end
    chk("t2_penable_cycles", cnt, 6);
    chk("t2_apb_stable", bad, 0);
    wait_rsp(0, "t2");

    // 3: read slave error
    rdata_v = 32'h1234_5678; pready_dly = 1; slverr_on = 1'b1;
    send(0, 1, 32'h1000_000C, 4'b0, 32'h0, 2'b01, 32'h0);
    wait_rsp(0, "t3");
    slverr_on = 1'b0;

    // 4: timeout on the TMO_CYC=4 instance, then PREADY exactly on the timeout cycle
    hang = 1'b1;
    send(1, 1, 32'h2000_0000, 4'b0, 32'h0, 2'b10, 32'h0);
    cnt = 0;
    for (int i = 0; i < 40 && !rsp_vld2; i++) begin
      @(negedge clk);
      if (psel2 & penable2) cnt++;
    end
    chk("t4_access_cycles", cnt, 4);
    chk("t4_psel_dropped", psel2, 0);
    wait_rsp(1, "t4");
    hang = 1'b0; pready_dly = 3; rdata_v = 32'hCAFE_F00D;
    send(1, 1, 32'h2000_0004, 4'b0, 32'h0, 2'b00, 32'hCAFE_F00D);
    wait_rsp(1, "t4_edge");
    pready_dly = 0;
    send(1, 0, 32'h2000_0008, 4'b1111, 32'h7777_8888, 2'b00, 32'h0);
    wait_rsp(1, "t4_next");

    // 5: response back-pressure with a queued request
    rsp_rdy = 1'b0; rdata_v = 32'h55AA_33CC;
    send(0, 1, 32'h1000_0010, 4'b0, 32'h0, 2'b00, 32'h55AA_33CC);
    for (int i = 0; i < 20 && !rsp_vld; i++) @(negedge clk);
    req_read = 1'b0; req_addr = 32'h1000_0014; req_mask = 4'hF; req_data = 32'h1111_2222;
    req_vld = 1'b1;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      if (rsp_vld !== 1'b1 || rsp_data !== 32'h55AA_33CC || rsp_excp !== 2'b00 || req_rdy !== 1'b0) bad++;
      @(negedge clk);
    end
    chk("t5_held_stable", bad, 0);
    chk("t5_req_blocked", req_rdy, 0);
    rsp_rdy = 1'b1;
    e = sb.pop_front();
    chk("t5a_data", rsp_data, e.data);
    chk("t5a_excp", rsp_excp, e.excp);
    @(negedge clk);
    chk("t5_rdy_after_hs", req_rdy, 1);
    chk("t5_rsp_dropped", rsp_vld, 0);
    e.excp = 2'b00; e.data = 32'h0;
    sb.push_back(e);
    @(posedge clk);
    #1 req_vld = 1'b0;
    wait_rsp(0, "t5b");

    // 6: reset during ACCESS
    pready_dly = 3;
    send(0, 0, 32'h1000_0020, 4'hF, 32'h9999_0000, 2'b00, 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk("t6_in_access", penable, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_psel_async", psel, 0);
    chk("t6_penable_async", penable, 0);
    chk("t6_rsp_vld_async", rsp_vld, 0);
    chk("t6_req_rdy_rst", req_rdy, 1);
    chk("t6_paddr_rst", paddr, 0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (rsp_vld !== 1'b0 || psel !== 1'b0) bad++;
    end
    chk("t6_no_stale_rsp", bad, 0);
    pready_dly = 0;
    send(0, 0, 32'h1000_0024, 4'hF, 32'h0BAD_F00D, 2'b00, 32'h0);
    @(negedge clk);
    chk("t6_pwdata", pwdata, 32'h0BAD_F00D);
    wait_rsp(0, "t6");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1);
  end

endmodule
